// File: rtl/pico_ctrl_pkg.sv
// Shared types for the picoMips fetch/decode controller.
//   op_t    : 3-bit opcode carried in the top field of every instruction word
//   state_t : controller sequencing states
//   OP_W / IMM_W : fixed field widths of the instruction word
package pico_ctrl_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned IMM_W = 8;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_ADDI = 3'd1,
    OP_MULI = 3'd2,
    OP_RTA  = 3'd3,
    OP_LSW  = 3'd4,
    OP_STA  = 3'd5,
    OP_JMP  = 3'd6,
    OP_WSW  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_EXEC,
    ST_WAIT
  } state_t;

endpackage

// File: rtl/pico_ctrl_if.sv
// ALU / register-file control bundle driven by the controller.
//   Func    : ALU function (opcode)
//   WE      : accumulator write enable
//   SelSW   : select switches as operand
//   SelImm  : select immediate as operand
//   Imm     : 8-bit immediate
//   RegAddr : register-file address
//   RegWE   : register-file write enable
// master = controller (producer), slave = datapath (consumer).
interface pico_ctrl_if #(
  parameter int unsigned REG_AW = 3
);
  logic [2:0]        Func;
  logic              WE;
  logic              SelSW;
  logic              SelImm;
  logic [7:0]        Imm;
  logic [REG_AW-1:0] RegAddr;
  logic              RegWE;

  modport master (output Func, WE, SelSW, SelImm, Imm, RegAddr, RegWE);
  modport slave  (input  Func, WE, SelSW, SelImm, Imm, RegAddr, RegWE);
endinterface

// File: rtl/pico_ctrl_btn_edge.sv
// Button synchroniser and rising-edge detector.
//   Clock, Reset (async, active-high), Button (raw asynchronous input)
//   Pulse : one-cycle pulse per synchronised 0->1 transition of Button
module pico_btn_edge (
  input  logic Clock,
  input  logic Reset,
  input  logic Button,
  output logic Pulse
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= Button;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign Pulse = s2_q & ~s3_q;

endmodule

// File: rtl/pico_ctrl.sv
// picoMips fetch/decode controller.
//   Clock, Reset : system clock, asynchronous active-high reset
//   ProgAddr     : ROM read address of the next instruction
//   ProgData     : ROM word {op, reg, imm}, valid one cycle after ProgAddr
//   Button       : raw user button used by WSW to pace execution
//   alu          : ALU / register-file control bundle (master side)
//   Waiting      : high while stalled on WSW
module pico_ctrl
  import pico_ctrl_pkg::*;
#(
  parameter  int unsigned PC_W    = 6,
  parameter  int unsigned REG_AW  = 3,
  localparam int unsigned INSTR_W = OP_W + REG_AW + IMM_W
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [PC_W-1:0]    ProgAddr,
  input  logic [INSTR_W-1:0] ProgData,
  input  logic               Button,
  pico_ctrl_if.master        alu,
  output logic               Waiting
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;
  logic            btn_pulse;
  op_t             op;
  logic            we, sel_sw, sel_imm, reg_we;

  pico_btn_edge u_btn (
    .Clock  (Clock),
    .Reset  (Reset),
    .Button (Button),
    .Pulse  (btn_pulse)
  );

  assign op     = op_t'(ProgData[INSTR_W-1 -: OP_W]);
  assign pc_inc = pc_q + PC_W'(1);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_FILL;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // pc always records the address just issued to the ROM, so it names the
  // instruction presented on ProgData in the following cycle.
  always_comb begin
    state_d  = state_q;
    ProgAddr = pc_q;
    we       = 1'b0;
    sel_sw   = 1'b0;
    sel_imm  = 1'b0;
    reg_we   = 1'b0;
    Waiting  = 1'b0;
    case (state_q)
      ST_FILL: begin
        ProgAddr = '0;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        ProgAddr = pc_inc;
        case (op)
          OP_JMP: ProgAddr = ProgData[PC_W-1:0];
          OP_WSW: begin
            ProgAddr = pc_q;
            state_d  = ST_WAIT;
          end
          OP_STA: reg_we = 1'b1;
          OP_ADDI, OP_MULI: begin
            we      = 1'b1;
            sel_imm = 1'b1;
          end
          OP_LSW: begin
            we     = 1'b1;
            sel_sw = 1'b1;
          end
          default: we = 1'b1;
        endcase
      end
      ST_WAIT: begin
        Waiting = 1'b1;
        if (btn_pulse) begin
          ProgAddr = pc_inc;
          state_d  = ST_EXEC;
        end
      end
      default: begin
        ProgAddr = '0;
        state_d  = ST_FILL;
      end
    endcase
    pc_d = ProgAddr;
  end

  assign alu.Func    = ProgData[INSTR_W-1 -: OP_W];
  assign alu.Imm     = ProgData[IMM_W-1:0];
  assign alu.RegAddr = ProgData[IMM_W +: REG_AW];
  assign alu.WE      = we;
  assign alu.SelSW   = sel_sw;
  assign alu.SelImm  = sel_imm;
  assign alu.RegWE   = reg_we;

endmodule

// File: tb/tb_pico_ctrl.sv
module tb_pico_ctrl;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Button = 1'b0;
  logic [5:0]  ProgAddr;
  logic [13:0] ProgData;
  logic        Waiting;

  pico_ctrl_if #(.REG_AW(3)) alu_if ();

  pico_ctrl #(.PC_W(6), .REG_AW(3)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .ProgAddr (ProgAddr),
    .ProgData (ProgData),
    .Button   (Button),
    .alu      (alu_if),
    .Waiting  (Waiting)
  );

  always #5 Clock = ~Clock;

  // Synchronous program ROM
  logic [13:0] rom [64];
  always @(posedge Clock) ProgData <= rom[ProgAddr];

  typedef struct packed {
    logic [5:0] addr;
    logic [2:0] func;
    logic [7:0] imm;
    logic [2:0] ra;
    logic       we;
    logic       selsw;
    logic       selimm;
    logic       regwe;
    logic       waiting;
  } obs_t;

  typedef enum int {M_FILL, M_RUN, M_WAIT} mmode_t;

  obs_t   sb[$];
  int     total = 0;
  int     bad   = 0;

  // Reference model state: what the controller is doing this cycle
  mmode_t m_mode = M_FILL;
  int     m_pc   = 0;
  logic   m_q0 = 1'b0, m_q1 = 1'b0, m_q2 = 1'b0;  // button samples, newest first

  function automatic logic [13:0] enc(input int op, input int rg, input int imm);
    logic [13:0] w;
    w[13:11] = 3'(op);
    w[10:8]  = 3'(rg);
    w[7:0]   = 8'(imm);
    return w;
  endfunction

  // Expected outputs for the current cycle, from the instruction semantics
  function automatic obs_t predict();
    obs_t        o;
    logic [13:0] w;
    int          op;
    logic        edge_seen;
    w         = rom[m_pc];
    op        = int'(w[13:11]);
    edge_seen = m_q1 && !m_q2;
    o         = '0;
    o.func    = w[13:11];
    o.imm     = w[7:0];
    o.ra      = w[10:8];
    case (m_mode)
      M_FILL: o.addr = 6'd0;
      M_RUN: begin
        if (op == 6)      o.addr = w[5:0];
        else if (op == 7) o.addr = 6'(m_pc);
        else              o.addr = 6'((m_pc + 1) % 64);
        o.we     = (op <= 4);
        o.selimm = (op == 1 || op == 2);
        o.selsw  = (op == 4);
        o.regwe  = (op == 5);
      end
      default: begin
        o.waiting = 1'b1;
        o.addr    = edge_seen ? 6'((m_pc + 1) % 64) : 6'(m_pc);
      end
    endcase
    return o;
  endfunction

  task automatic tick();
    obs_t        cur;
    logic        edge_seen;
    @(posedge Clock);
    if (Reset) begin
      m_mode = M_FILL;
      m_pc   = 0;
      m_q0   = 1'b0;
      m_q1   = 1'b0;
      m_q2   = 1'b0;
    end else begin
      cur       = predict();
      edge_seen = m_q1 && !m_q2;
      case (m_mode)
        M_FILL: m_mode = M_RUN;
        M_RUN:  if (cur.func == 3'd7) m_mode = M_WAIT;
        default: if (edge_seen) m_mode = M_RUN;
      endcase
      m_pc = int'(cur.addr);
      m_q2 = m_q1;
      m_q1 = m_q0;
      m_q0 = Button;
    end
    sb.push_back(predict());
  endtask

  task automatic run(input int n, input logic b);
    repeat (n) begin
      Button = b;
      tick();
      @(negedge Clock);
      #1;
    end
  endtask

  task automatic run_random(input int n);
    repeat (n) begin
      if ($urandom_range(0, 3) == 0) Button = ~Button;
      tick();
      @(negedge Clock);
      #1;
    end
  endtask

  // Entered at negedge+1; asserts reset between clock edges.
  task automatic async_reset(input logic expect_wait);
    if (expect_wait) begin
      total++;
      if (m_mode != M_WAIT) begin
        bad++;
        $display("FAIL rst_setup: controller not waiting before reset, model mode=%0d want=%0d", m_mode, M_WAIT);
      end
    end
    #1 Reset = 1'b1;
    #1;
    total++;
    if (Waiting !== 1'b0 || ProgAddr !== 6'd0 ||
        {alu_if.WE, alu_if.SelSW, alu_if.SelImm, alu_if.RegWE} !== 4'b0) begin
      bad++;
      $display("FAIL async_reset: got Waiting=%b ProgAddr=%h en=%b, want Waiting=0 ProgAddr=00 en=0000",
               Waiting, ProgAddr, {alu_if.WE, alu_if.SelSW, alu_if.SelImm, alu_if.RegWE});
    end
    run(2, Button);
    Reset = 1'b0;
  endtask

  // Monitor: one observation per cycle, compared against the queued expectation
  always @(negedge Clock) begin
    obs_t act, exp_o;
    if (sb.size() > 0) begin
      exp_o       = sb.pop_front();
      act.addr    = ProgAddr;
      act.func    = alu_if.Func;
      act.imm     = alu_if.Imm;
      act.ra      = alu_if.RegAddr;
      act.we      = alu_if.WE;
      act.selsw   = alu_if.SelSW;
      act.selimm  = alu_if.SelImm;
      act.regwe   = alu_if.RegWE;
      act.waiting = Waiting;
      total++;
      if (act !== exp_o) begin
        bad++;
        $display("FAIL cycle_obs t=%0t got addr=%h func=%0d imm=%h ra=%0d we=%b sw=%b si=%b rwe=%b wt=%b | want addr=%h func=%0d imm=%h ra=%0d we=%b sw=%b si=%b rwe=%b wt=%b",
                 $time, act.addr, act.func, act.imm, act.ra, act.we, act.selsw, act.selimm, act.regwe, act.waiting,
                 exp_o.addr, exp_o.func, exp_o.imm, exp_o.ra, exp_o.we, exp_o.selsw, exp_o.selimm, exp_o.regwe, exp_o.waiting);
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = enc(0, i % 8, i);
    rom[0]  = enc(1, 0, 5);                         // ADDI r0 5
    rom[1]  = enc(2, $urandom_range(0, 7), 3);      // MULI 3
    rom[2]  = enc(4, $urandom_range(0, 7), $urandom_range(0, 255));  // LSW
    rom[3]  = enc(3, 2, $urandom_range(0, 255));    // RTA
    rom[4]  = enc(6, 0, 8'h2A);                     // JMP 0x2A
    rom[42] = enc(6, 1, 8'hC5);                     // JMP 5 (upper imm bits ignored)
    rom[5]  = enc(0, 1, $urandom_range(0, 255));    // ADD r1
    rom[6]  = enc(5, 5, $urandom_range(0, 255));    // STA r5
    rom[7]  = enc(7, 0, 0);                         // WSW
    rom[8]  = enc(1, 3, 8'h11);                     // ADDI
    rom[9]  = enc(7, 0, 0);                         // WSW
    rom[10] = enc(6, 0, 8'h3E);                     // JMP 62
    rom[62] = enc(4, 6, 8'h77);                     // LSW
    rom[63] = enc(1, 7, 8'h80);                     // ADDI, pc wraps to 0 after

    @(posedge Clock);
    @(negedge Clock);
    #1;
    run(2, 1'b0);           // reset held
    Reset = 1'b0;
    run(1, 1'b0);
    run(2, 1'b1);           // button edge during plain execution
    run(10, 1'b0);          // reaches WSW at 7, edge already consumed
    run(6, 1'b0);
    run(15, 1'b1);          // release from 7; still held at WSW 9
    run(3, 1'b0);
    run(3, 1'b1);           // fresh edge releases 9
    run(20, 1'b0);          // 10 -> 62 -> 63 -> 0 ... -> WSW at 7
    async_reset(1'b1);
    run(8, 1'b0);

    for (int p = 0; p < 3; p++) begin
      #1 Reset = 1'b1;
      for (int i = 0; i < 64; i++) rom[i] = 14'($urandom);
      run(2, 1'b0);
      Reset = 1'b0;
      run_random(300);
      async_reset(1'b0);
      run_random(300);
    end

    @(negedge Clock);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
